mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit for a 32-bit little-endian memory slave with waitrequest.
// Handles MIPS-style LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW, alignment errors and a stall timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_we,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_wdata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE. The memory side transfers on a rising edge in
  // ISSUE with mem_waitrequest low; resp_valid is a single-cycle pulse, never stalled.

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RDATA = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;
  logic [15:0] wait_cnt;

  logic [1:0]  req_off;
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wd;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] lwl_keep;
  logic [31:0] lwr_keep;
  logic [31:0] load_data;

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;
  assign req_off   = req_addr[1:0];

  // Request decode: lane enables, replicated store data and the error condition.
  always_comb begin
    req_bad = 1'b0;
    req_be  = 4'b0000;
    req_wd  = 32'h0;
    case (req_op)
      OP_LB, OP_LBU: req_be = 4'b0001 << req_off;
      OP_LH, OP_LHU: begin
        req_bad = req_off[0];
        req_be  = req_off[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        req_bad = (req_off != 2'd0);
        req_be  = 4'b1111;
      end
      OP_LWL: req_be = 4'b1111 >> (~req_off);
      OP_LWR: req_be = 4'b1111 << req_off;
      OP_SB: begin
        req_be = 4'b0001 << req_off;
        req_wd = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        req_bad = req_off[0];
        req_be  = req_off[1] ? 4'b1100 : 4'b0011;
        req_wd  = {2{req_wdata[15:0]}};
      end
      OP_SW: begin
        req_bad = (req_off != 2'd0);
        req_be  = 4'b1111;
        req_wd  = req_wdata;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Load alignment: LWL keeps the low (3-off) bytes of rt, LWR keeps the high off bytes.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    lwl_keep = ~(32'hFFFF_FFFF << {~off_q, 3'b000});
    lwr_keep = ~(32'hFFFF_FFFF >> {off_q, 3'b000});
    load_data = 32'h0;
    case (op_q)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0, ld_half};
      OP_LW:   load_data = mem_rdata;
      OP_LWL:  load_data = (mem_rdata << {~off_q, 3'b000}) | (rt_q & lwl_keep);
      OP_LWR:  load_data = (mem_rdata >> {off_q, 3'b000}) | (rt_q & lwr_keep);
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      op_q           <= 4'h0;
      off_q          <= 2'd0;
      rt_q           <= 32'h0;
      wait_cnt       <= 16'h0;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_err       <= 1'b0;
      mem_addr       <= 32'h0;
      mem_read       <= 1'b0;
      mem_we         <= 1'b0;
      mem_byteenable <= 4'b0000;
      mem_wdata      <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            off_q <= req_off;
            rt_q  <= req_rt;
            if (req_bad) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state          <= S_ISSUE;
              wait_cnt       <= 16'h0;
              mem_addr       <= {req_addr[31:2], 2'b00};
              mem_read       <= ~req_op[3];
              mem_we         <= req_op[3];
              mem_byteenable <= req_be;
              mem_wdata      <= req_wd;
            end
          end
        end
        S_ISSUE: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            mem_we   <= 1'b0;
            if (op_q[3]) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
            end else begin
              state <= S_RDATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            // Abandon on the edge the count reaches TIMEOUT; a store is not retried.
            if (wait_cnt == LAST_WAIT) begin
              mem_read   <= 1'b0;
              mem_we     <= 1'b0;
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end
          end
        end
        S_RDATA: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_data;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table through a scoreboard queue, plus
// hand-written sequences for mid-access reset and back-to-back requests.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rt = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_we;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_wdata;
  logic        mem_waitrequest;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_we(mem_we),
    .mem_byteenable(mem_byteenable), .mem_wdata(mem_wdata),
    .mem_waitrequest(mem_waitrequest), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory slave: stalls stall_n cycles per access, returns registered read data.
  int          stall_n = 0;
  int          stall_cnt = 0;
  logic [31:0] slave_word = 32'h0;

  assign mem_waitrequest = (mem_read || mem_we) && (stall_cnt < stall_n);

  always @(posedge clk) begin
    if ((mem_read || mem_we) && mem_waitrequest) stall_cnt <= stall_cnt + 1;
    else if (!(mem_read || mem_we)) stall_cnt <= 0;
    mem_rdata <= (mem_read && !mem_waitrequest) ? slave_word : 32'hDEAD_BEEF;
  end

  // Scoreboard: {err, rdata} pushed when a request is driven, popped on resp_valid.
  logic [32:0] exp_q[$];
  int          act_cycles = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [31:0] obs_addr;
  logic        obs_we;

  always @(negedge clk) begin
    if (mem_read || mem_we) begin
      act_cycles++;
      obs_be    = mem_byteenable;
      obs_wdata = mem_wdata;
      obs_addr  = mem_addr;
      obs_we    = mem_we;
      chk("rd_we_exclusive", 32'(mem_read && mem_we), 32'd0);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[31:0]);
        chk("resp_err", 32'(resp_err), 32'(e[32]));
      end
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] word;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lat;
    int          exp_act;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rt, input logic [31:0] word, input int stall,
                              input logic [31:0] exp_rdata, input logic exp_err, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input int exp_lat, input int exp_act);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rt = rt; v.word = word; v.stall = stall;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_lat = exp_lat; v.exp_act = exp_act;
    return v;
  endfunction

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      if (req_ready) break;
      @(negedge clk); #1;
    end
    chk("wait_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_byteenable), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit seen;
    @(negedge clk); #1;
    wait_ready();
    act_cycles = 0;
    slave_word = v.word;
    stall_n    = v.stall;
    req_valid  = 1'b1;
    req_op     = v.op;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rt     = v.rt;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("resp_latency", 32'(k), 32'(v.exp_lat));
    if (!seen) exp_q.delete();
    chk("mem_active_cycles", 32'(act_cycles), 32'(v.exp_act));
    if (v.exp_act != 0) begin
      chk("mem_byteenable", 32'(obs_be), 32'(v.exp_be));
      chk("mem_addr", obs_addr, {v.addr[31:2], 2'b00});
      chk("mem_we_dir", 32'(obs_we), 32'(v.op[3]));
      if (v.op[3]) chk("mem_wdata", obs_wdata, v.exp_wdata);
    end
    @(negedge clk); #1;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     addr          wdata         rt            word          st   rdata         err   be       wdata         lat act
    vt.push_back(mk(4'd0, 32'hBFC0_0003, 32'h0,        32'h0,        32'h80FF_0000, 0, 32'hFFFF_FF80, 1'b0, 4'b1000, 32'h0,        3, 1));
    vt.push_back(mk(4'd9, 32'h1000_0002, 32'h1234_ABCD, 32'h0,       32'h0,        0, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 2, 1));
    vt.push_back(mk(4'd4, 32'h1000_0001, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd7, 32'h1000_0000, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd5, 32'h2000_0001, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 32'h2211_CCDD, 1'b0, 4'b0011, 32'h0,      3, 1));
    vt.push_back(mk(4'd6, 32'h2000_0001, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 32'hAA44_3322, 1'b0, 4'b1110, 32'h0,      3, 1));
    vt.push_back(mk(4'd1, 32'h0000_0002, 32'h0,        32'h0,        32'h80FF_0000, 0, 32'h0000_00FF, 1'b0, 4'b0100, 32'h0,       3, 1));
    vt.push_back(mk(4'd2, 32'h0000_0002, 32'h0,        32'h0,        32'h80FF_0000, 0, 32'hFFFF_80FF, 1'b0, 4'b1100, 32'h0,       3, 1));
    vt.push_back(mk(4'd3, 32'h0000_0000, 32'h0,        32'h0,        32'h1234_F00D, 0, 32'h0000_F00D, 1'b0, 4'b0011, 32'h0,       3, 1));
    vt.push_back(mk(4'd4, 32'h0000_0100, 32'h0,        32'h0,        32'hCAFE_BABE, 2, 32'hCAFE_BABE, 1'b0, 4'b1111, 32'h0,       5, 3));
    vt.push_back(mk(4'd8, 32'h0000_0001, 32'h1234_56A5, 32'h0,       32'h0,        0, 32'h0,        1'b0, 4'b0010, 32'hA5A5_A5A5, 2, 1));
    vt.push_back(mk(4'd10, 32'h0000_0010, 32'h89AB_CDEF, 32'h0,      32'h0,        1, 32'h0,        1'b0, 4'b1111, 32'h89AB_CDEF, 3, 2));
    vt.push_back(mk(4'd4, 32'h0000_0040, 32'h0,        32'h0,        32'h1234_5678, 100, 32'h0,      1'b1, 4'b1111, 32'h0,        5, 4));
    vt.push_back(mk(4'd10, 32'h0000_0044, 32'h0BAD_F00D, 32'h0,      32'h0,        100, 32'h0,      1'b1, 4'b1111, 32'h0BAD_F00D, 5, 4));
    vt.push_back(mk(4'd4, 32'h0000_0048, 32'h0,        32'h0,        32'h1234_5678, 4, 32'h0,        1'b1, 4'b1111, 32'h0,        5, 4));
    vt.push_back(mk(4'd2, 32'h0000_0002, 32'h0,        32'h0,        32'h7FFF_0000, 3, 32'h0000_7FFF, 1'b0, 4'b1100, 32'h0,       6, 4));
    vt.push_back(mk(4'd2, 32'h0000_0001, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd3, 32'h0000_0003, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd9, 32'h0000_0003, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd10, 32'h0000_0002, 32'h0,       32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd15, 32'h0000_0000, 32'h0,       32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd11, 32'h0000_0000, 32'h0,       32'h0,        32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0));
    vt.push_back(mk(4'd5, 32'h0000_0003, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 32'h4433_2211, 1'b0, 4'b1111, 32'h0,      3, 1));
    vt.push_back(mk(4'd6, 32'h0000_0000, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 32'h4433_2211, 1'b0, 4'b1111, 32'h0,      3, 1));
    vt.push_back(mk(4'd5, 32'h0000_0000, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 32'h11BB_CCDD, 1'b0, 4'b0001, 32'h0,      3, 1));
    vt.push_back(mk(4'd6, 32'h0000_0003, 32'h0,        32'hAABB_CCDD, 32'h4433_2211, 0, 32'hAABB_CC44, 1'b0, 4'b1000, 32'h0,      3, 1));
    vt.push_back(mk(4'd0, 32'h0000_0001, 32'h0,        32'h0,        32'h80FF_7F00, 0, 32'h0000_007F, 1'b0, 4'b0010, 32'h0,       3, 1));
    vt.push_back(mk(4'd8, 32'h0000_0007, 32'hFFFF_FF3C, 32'h0,       32'h0,        0, 32'h0,        1'b0, 4'b1000, 32'h3C3C_3C3C, 2, 1));
    vt.push_back(mk(4'd4, 32'h7FFF_FFFC, 32'h0,        32'h0,        32'h0000_8001, 0, 32'h0000_8001, 1'b0, 4'b1111, 32'h0,       3, 1));

    // Reset phase
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);

    // Reset pulsed during ISSUE: access dropped without a clock edge, never answered
    @(negedge clk); #1;
    wait_ready();
    stall_n   = 100;
    req_valid = 1'b1;
    req_op    = 4'd4;
    req_addr  = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("issue_mem_read", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk); #1;
    rst_n   = 1'b1;
    stall_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("no_resp_after_reset", 32'(resp_valid), 32'd0);
    end
    run_vec(mk(4'd4, 32'h0000_0080, 32'h0, 32'h0, 32'h5566_7788, 0, 32'h5566_7788, 1'b0, 4'b1111, 32'h0, 3, 1));

    // req_valid held high: ignored while busy, next request accepted in the cycle after RESP
    @(negedge clk); #1;
    wait_ready();
    slave_word = 32'h1111_2222;
    stall_n    = 0;
    req_valid  = 1'b1;
    req_op     = 4'd4;
    req_addr   = 32'h0000_0200;
    req_wdata  = 32'h0;
    exp_q.push_back({1'b0, 32'h1111_2222});
    @(posedge clk); #1;
    req_op    = 4'd8;
    req_addr  = 32'h0000_0301;
    req_wdata = 32'h0000_005A;
    exp_q.push_back({1'b0, 32'h0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      chk("busy_not_ready", 32'(req_ready), 32'd0);
      if (c == 1) chk("busy_mem_addr", mem_addr, 32'h0000_0200);
      if (c == 3) chk("b2b_first_resp", 32'(resp_valid), 32'd1);
    end
    @(negedge clk); #1;
    chk("b2b_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b_mem_we", 32'(mem_we), 32'd1);
    chk("b2b_be", 32'(mem_byteenable), 32'b0010);
    chk("b2b_wdata", mem_wdata, 32'h5A5A_5A5A);
    chk("b2b_addr", mem_addr, 32'h0000_0300);
    @(negedge clk); #1;
    chk("b2b_second_resp", 32'(resp_valid), 32'd1);
    @(negedge clk); #1;
    chk("b2b_resp_done", 32'(resp_valid), 32'd0);

    repeat (4) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
